// File: rtl/rob_buffer_pkg.sv
// Shared reorder-buffer constants and types.
// Entry count, widths and entry-type encodings.
package rob_buffer_pkg;
  localparam int ROB_BIT  = 4;
  localparam int ROB_SIZE = 1 << ROB_BIT;
  localparam int XLEN     = 32;
  localparam int REG_BIT  = 5;

  typedef logic [ROB_BIT-1:0] rob_tag_t;
  typedef logic [ROB_BIT:0]   rob_cnt_t;
  typedef logic [XLEN-1:0]    word_t;
  typedef logic [REG_BIT-1:0] reg_id_t;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2,
    ROB_HALT   = 2'd3
  } rob_type_e;
endpackage

// File: rtl/rob_buffer_if.sv
// Reorder-buffer bus: issue, CDBs, queries, commit.
// master drives issue/CDB/query, slave is the ROB.
interface rob_buffer_if;
  import rob_buffer_pkg::*;

  logic     issue_valid;
  logic [1:0] issue_type;
  reg_id_t  issue_rd;
  word_t    issue_pc;
  logic     issue_pred_taken;
  logic     issue_ready;
  word_t    issue_value;
  logic     rob_full;
  rob_tag_t issue_rob_entry;

  logic     rs_cdb_valid;
  rob_tag_t rs_cdb_entry;
  word_t    rs_cdb_value;
  word_t    rs_cdb_addr;
  logic     lsb_cdb_valid;
  rob_tag_t lsb_cdb_entry;
  word_t    lsb_cdb_value;

  rob_tag_t get_rob_entry1;
  rob_tag_t get_rob_entry2;
  logic     ready1;
  logic     ready2;
  word_t    value1;
  word_t    value2;

  reg_id_t  commit_reg_id;
  word_t    commit_reg_data;
  rob_tag_t commit_rob_entry;
  logic     commit_store;
  rob_tag_t rob_head;
  logic     rob_clear_up;
  word_t    jump_pc;
  logic     halt_out;

  modport slave (
    input  issue_valid, issue_type, issue_rd,
    input  issue_pc, issue_pred_taken,
    input  issue_ready, issue_value,
    output rob_full, issue_rob_entry,
    input  rs_cdb_valid, rs_cdb_entry,
    input  rs_cdb_value, rs_cdb_addr,
    input  lsb_cdb_valid, lsb_cdb_entry,
    input  lsb_cdb_value,
    input  get_rob_entry1, get_rob_entry2,
    output ready1, ready2, value1, value2,
    output commit_reg_id, commit_reg_data,
    output commit_rob_entry, commit_store,
    output rob_head, rob_clear_up,
    output jump_pc, halt_out
  );

  modport master (
    output issue_valid, issue_type, issue_rd,
    output issue_pc, issue_pred_taken,
    output issue_ready, issue_value,
    input  rob_full, issue_rob_entry,
    output rs_cdb_valid, rs_cdb_entry,
    output rs_cdb_value, rs_cdb_addr,
    output lsb_cdb_valid, lsb_cdb_entry,
    output lsb_cdb_value,
    output get_rob_entry1, get_rob_entry2,
    input  ready1, ready2, value1, value2,
    input  commit_reg_id, commit_reg_data,
    input  commit_rob_entry, commit_store,
    input  rob_head, rob_clear_up,
    input  jump_pc, halt_out
  );
endinterface

// File: rtl/rob_buffer_query.sv
// Operand lookup by ROB tag with CDB bypass.
// Free entries report ready; rs CDB wins over lsb CDB.
module rob_query_port
  import rob_buffer_pkg::*;
(
  input  rob_tag_t                tag_i,
  input  logic [ROB_SIZE-1:0]     busy_i,
  input  logic [ROB_SIZE-1:0]     ready_i,
  input  word_t [ROB_SIZE-1:0]    value_i,
  input  logic                    rs_valid_i,
  input  rob_tag_t                rs_entry_i,
  input  word_t                   rs_value_i,
  input  logic                    lsb_valid_i,
  input  rob_tag_t                lsb_entry_i,
  input  word_t                   lsb_value_i,
  output logic                    ready_o,
  output word_t                   value_o
);
  logic rs_hit;
  logic lsb_hit;

  assign rs_hit  = rs_valid_i && (rs_entry_i == tag_i);
  assign lsb_hit = lsb_valid_i && (lsb_entry_i == tag_i);

  // Stored result unless a CDB broadcasts this tag now.
  always_comb begin
    ready_o = !busy_i[tag_i] || ready_i[tag_i];
    value_o = value_i[tag_i];
    unique case (1'b1)
      rs_hit: begin
        ready_o = 1'b1;
        value_o = rs_value_i;
      end
      lsb_hit: begin
        ready_o = 1'b1;
        value_o = lsb_value_i;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/rob_buffer.sv
// In-order commit reorder buffer, 2^ROB_BIT entries.
// Captures two CDBs, answers queries, flushes on mispredict.
module rob_buffer
  import rob_buffer_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  rob_buffer_if.slave   bus
);
  logic [ROB_SIZE-1:0]  busy_q;
  logic [ROB_SIZE-1:0]  ready_q;
  logic [ROB_SIZE-1:0]  pred_q;
  word_t [ROB_SIZE-1:0] value_q;
  rob_type_e            type_q [ROB_SIZE];
  reg_id_t              rd_q   [ROB_SIZE];
  word_t                pc_q   [ROB_SIZE];
  word_t                addr_q [ROB_SIZE];

  rob_tag_t head_q, head_d;
  rob_tag_t tail_q, tail_d;
  rob_cnt_t count_q, count_d;

  reg_id_t  creg_id_q, creg_id_d;
  word_t    cdata_q, cdata_d;
  rob_tag_t centry_q, centry_d;
  logic     cstore_q, cstore_d;
  logic     clear_q, clear_d;
  word_t    jump_q, jump_d;
  logic     halt_q, halt_d;

  logic full;
  logic do_issue;
  logic do_commit;
  logic rs_wr;
  logic lsb_wr;
  logic mispred;

  assign full     = (count_q == rob_cnt_t'(ROB_SIZE));
  assign do_issue = bus.issue_valid && !full
                  && !clear_q && !halt_q;
  assign do_commit = busy_q[head_q] && ready_q[head_q]
                   && !clear_q && !halt_q;
  assign rs_wr  = bus.rs_cdb_valid
                && busy_q[bus.rs_cdb_entry];
  assign lsb_wr = bus.lsb_cdb_valid
                && busy_q[bus.lsb_cdb_entry];
  assign mispred = value_q[head_q][0] != pred_q[head_q];

  // Pointer, occupancy and commit-output next state.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    creg_id_d = '0;
    cdata_d  = cdata_q;
    centry_d = centry_q;
    cstore_d = 1'b0;
    clear_d  = 1'b0;
    jump_d   = jump_q;
    halt_d   = halt_q;
    if (clear_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_issue)
        tail_d = tail_q + rob_tag_t'(1);
      if (do_issue && !do_commit)
        count_d = count_q + rob_cnt_t'(1);
      if (!do_issue && do_commit)
        count_d = count_q - rob_cnt_t'(1);
      if (do_commit) begin
        head_d   = head_q + rob_tag_t'(1);
        centry_d = head_q;
        unique case (type_q[head_q])
          ROB_REG: begin
            creg_id_d = rd_q[head_q];
            cdata_d   = value_q[head_q];
          end
          ROB_STORE: cstore_d = 1'b1;
          ROB_HALT:  halt_d = 1'b1;
          ROB_BRANCH: begin
            if (mispred) begin
              clear_d = 1'b1;
              jump_d  = addr_q[head_q];
            end
          end
        endcase
      end
    end
  end

  // Pointer and registered-output state.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      creg_id_q <= '0;
      cdata_q   <= '0;
      centry_q  <= '0;
      cstore_q  <= 1'b0;
      clear_q   <= 1'b0;
      jump_q    <= '0;
      halt_q    <= 1'b0;
    end else if (rdy_in) begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      creg_id_q <= creg_id_d;
      cdata_q   <= cdata_d;
      centry_q  <= centry_d;
      cstore_q  <= cstore_d;
      clear_q   <= clear_d;
      jump_q    <= jump_d;
      halt_q    <= halt_d;
    end
  end

  // Entry array: writeback, retire, allocate, flush.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q <= '0;
    end else if (rdy_in) begin
      if (clear_q) begin
        busy_q <= '0;
      end else begin
        if (do_commit)
          busy_q[head_q] <= 1'b0;
        if (rs_wr) begin
          ready_q[bus.rs_cdb_entry] <= 1'b1;
          value_q[bus.rs_cdb_entry] <= bus.rs_cdb_value;
          addr_q[bus.rs_cdb_entry]  <= bus.rs_cdb_addr;
        end
        if (lsb_wr) begin
          ready_q[bus.lsb_cdb_entry] <= 1'b1;
          value_q[bus.lsb_cdb_entry] <= bus.lsb_cdb_value;
        end
        if (do_issue) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= bus.issue_ready;
          type_q[tail_q]  <= rob_type_e'(bus.issue_type);
          rd_q[tail_q]    <= bus.issue_rd;
          value_q[tail_q] <= bus.issue_value;
          pc_q[tail_q]    <= bus.issue_pc;
          pred_q[tail_q]  <= bus.issue_pred_taken;
        end
      end
    end
  end

  assign bus.rob_full         = full;
  assign bus.issue_rob_entry  = tail_q;
  assign bus.rob_head         = head_q;
  assign bus.commit_reg_id    = creg_id_q;
  assign bus.commit_reg_data  = cdata_q;
  assign bus.commit_rob_entry = centry_q;
  assign bus.commit_store     = cstore_q;
  assign bus.rob_clear_up     = clear_q;
  assign bus.jump_pc          = jump_q;
  assign bus.halt_out         = halt_q;

  rob_query_port u_query1 (
    .tag_i       (bus.get_rob_entry1),
    .busy_i      (busy_q),
    .ready_i     (ready_q),
    .value_i     (value_q),
    .rs_valid_i  (bus.rs_cdb_valid),
    .rs_entry_i  (bus.rs_cdb_entry),
    .rs_value_i  (bus.rs_cdb_value),
    .lsb_valid_i (bus.lsb_cdb_valid),
    .lsb_entry_i (bus.lsb_cdb_entry),
    .lsb_value_i (bus.lsb_cdb_value),
    .ready_o     (bus.ready1),
    .value_o     (bus.value1)
  );

  rob_query_port u_query2 (
    .tag_i       (bus.get_rob_entry2),
    .busy_i      (busy_q),
    .ready_i     (ready_q),
    .value_i     (value_q),
    .rs_valid_i  (bus.rs_cdb_valid),
    .rs_entry_i  (bus.rs_cdb_entry),
    .rs_value_i  (bus.rs_cdb_value),
    .lsb_valid_i (bus.lsb_cdb_valid),
    .lsb_entry_i (bus.lsb_cdb_entry),
    .lsb_value_i (bus.lsb_cdb_value),
    .ready_o     (bus.ready2),
    .value_o     (bus.value2)
  );
endmodule

// File: tb/tb_rob_buffer.sv
// Self-checking bench for rob_buffer.
// Register commits are predicted through a scoreboard queue.
module tb_rob_buffer;
  import rob_buffer_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  rob_buffer_if bus ();

  rob_buffer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  entry;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic tick;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle;
    bus.issue_valid      = 1'b0;
    bus.issue_type       = 2'd0;
    bus.issue_rd         = '0;
    bus.issue_pc         = '0;
    bus.issue_pred_taken = 1'b0;
    bus.issue_ready      = 1'b0;
    bus.issue_value      = '0;
    bus.rs_cdb_valid     = 1'b0;
    bus.rs_cdb_entry     = '0;
    bus.rs_cdb_value     = '0;
    bus.rs_cdb_addr      = '0;
    bus.lsb_cdb_valid    = 1'b0;
    bus.lsb_cdb_entry    = '0;
    bus.lsb_cdb_value    = '0;
    bus.get_rob_entry1   = '0;
    bus.get_rob_entry2   = '0;
  endtask

  task automatic do_reset;
    idle();
    rdy_in = 1'b1;
    rst_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  task automatic drive_issue(input logic [1:0] t,
                             input logic [4:0] rd,
                             input logic p,
                             input logic r,
                             input logic [31:0] v);
    idle();
    bus.issue_valid      = 1'b1;
    bus.issue_type       = t;
    bus.issue_rd         = rd;
    bus.issue_pc         = 32'h1000;
    bus.issue_pred_taken = p;
    bus.issue_ready      = r;
    bus.issue_value      = v;
  endtask

  task automatic test_reset;
    idle();
    rst_in = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.rob_full, bus.rob_clear_up, bus.halt_out,
         bus.commit_store} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000",
        {bus.rob_full, bus.rob_clear_up, bus.halt_out,
         bus.commit_store});
    end
    checks++;
    if (bus.commit_reg_id !== 5'd0) begin
      errors++;
      $display("FAIL reset_reg_id got=%0d want=0",
        bus.commit_reg_id);
    end
    checks++;
    if (bus.issue_rob_entry !== 4'd0 ||
        bus.rob_head !== 4'd0) begin
      errors++;
      $display("FAIL reset_ptrs tail=%0d head=%0d want=0/0",
        bus.issue_rob_entry, bus.rob_head);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_reg_commit;
    bit found;
    exp_t e;
    drive_issue(2'd0, 5'd5, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.issue_rob_entry !== 4'd0) begin
      errors++;
      $display("FAIL reg_tag got=%0d want=0", bus.issue_rob_entry);
    end
    tick();
    idle();
    bus.rs_cdb_valid = 1'b1;
    bus.rs_cdb_entry = 4'd0;
    bus.rs_cdb_value = 32'h1234;
    sb.push_back('{5'd5, 32'h1234, 4'd0});
    tick();
    idle();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.commit_reg_id != 5'd0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reg_commit timeout got=none want=commit");
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL reg_commit got=rd%0d want=no commit",
        bus.commit_reg_id);
    end else begin
      e = sb.pop_front();
      if ({bus.commit_reg_id, bus.commit_reg_data,
           bus.commit_rob_entry} !== {e.rd, e.data, e.entry}) begin
        errors++;
        $display("FAIL reg_commit got=%0d/%h/%0d want=%0d/%h/%0d",
          bus.commit_reg_id, bus.commit_reg_data,
          bus.commit_rob_entry, e.rd, e.data, e.entry);
      end
    end
    tick();
    checks++;
    if (bus.commit_reg_id !== 5'd0 || bus.rob_head !== 4'd1) begin
      errors++;
      $display("FAIL reg_pulse got=id%0d head%0d want=id0 head1",
        bus.commit_reg_id, bus.rob_head);
    end
  endtask

  task automatic test_full_wrap;
    bit found;
    exp_t e;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_issue(2'd0, 5'(i + 1), 1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.issue_rob_entry !== 4'(i)) begin
        errors++;
        $display("FAIL fill_tag got=%0d want=%0d",
          bus.issue_rob_entry, i);
      end
      tick();
    end
    idle();
    checks++;
    if (bus.rob_full !== 1'b1 || bus.issue_rob_entry !== 4'd0) begin
      errors++;
      $display("FAIL full_flag got=%b/%0d want=1/0",
        bus.rob_full, bus.issue_rob_entry);
    end
    drive_issue(2'd0, 5'd31, 1'b0, 1'b1, 32'hDEAD);
    tick();
    idle();
    checks++;
    if (bus.rob_full !== 1'b1 || bus.issue_rob_entry !== 4'd0) begin
      errors++;
      $display("FAIL full_refuse got=%b/%0d want=1/0",
        bus.rob_full, bus.issue_rob_entry);
    end
    bus.rs_cdb_valid = 1'b1;
    bus.rs_cdb_entry = 4'd0;
    bus.rs_cdb_value = 32'hA0;
    sb.push_back('{5'd1, 32'hA0, 4'd0});
    tick();
    idle();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.commit_reg_id != 5'd0) found = 1;
    end
    checks++;
    if (!found || sb.size() == 0) begin
      errors++;
      $display("FAIL full_commit got=found%0d want=found1", found);
    end else begin
      e = sb.pop_front();
      if ({bus.commit_reg_id, bus.commit_reg_data,
           bus.commit_rob_entry} !== {e.rd, e.data, e.entry}) begin
        errors++;
        $display("FAIL full_commit got=%0d/%h/%0d want=%0d/%h/%0d",
          bus.commit_reg_id, bus.commit_reg_data,
          bus.commit_rob_entry, e.rd, e.data, e.entry);
      end
    end
    checks++;
    if (bus.rob_full !== 1'b0 || bus.issue_rob_entry !== 4'd0) begin
      errors++;
      $display("FAIL full_drop got=%b/%0d want=0/0",
        bus.rob_full, bus.issue_rob_entry);
    end
    drive_issue(2'd0, 5'd2, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    checks++;
    if (bus.rob_full !== 1'b1 || bus.issue_rob_entry !== 4'd1) begin
      errors++;
      $display("FAIL wrap_issue got=%b/%0d want=1/1",
        bus.rob_full, bus.issue_rob_entry);
    end
  endtask

  task automatic test_query_bypass;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_issue(2'd0, 5'd0, 1'b0, (i == 1), 32'h55);
      tick();
    end
    idle();
    bus.get_rob_entry1 = 4'd3;
    bus.get_rob_entry2 = 4'd2;
    bus.rs_cdb_valid   = 1'b1;
    bus.rs_cdb_entry   = 4'd3;
    bus.rs_cdb_value   = 32'hABCD;
    #1;
    checks++;
    if (bus.ready1 !== 1'b1 || bus.value1 !== 32'hABCD ||
        bus.ready2 !== 1'b0) begin
      errors++;
      $display("FAIL rs_bypass got=%b/%h/%b want=1/0000abcd/0",
        bus.ready1, bus.value1, bus.ready2);
    end
    bus.lsb_cdb_valid = 1'b1;
    bus.lsb_cdb_entry = 4'd2;
    bus.lsb_cdb_value = 32'h77;
    #1;
    checks++;
    if (bus.ready2 !== 1'b1 || bus.value2 !== 32'h77) begin
      errors++;
      $display("FAIL lsb_bypass got=%b/%h want=1/00000077",
        bus.ready2, bus.value2);
    end
    bus.get_rob_entry1 = 4'd1;
    bus.rs_cdb_valid   = 1'b0;
    bus.lsb_cdb_valid  = 1'b0;
    #1;
    checks++;
    if (bus.ready1 !== 1'b1 || bus.value1 !== 32'h55) begin
      errors++;
      $display("FAIL stored_query got=%b/%h want=1/00000055",
        bus.ready1, bus.value1);
    end
    bus.rs_cdb_valid  = 1'b1;
    bus.lsb_cdb_valid = 1'b1;
    tick();
    idle();
    bus.get_rob_entry1 = 4'd3;
    bus.get_rob_entry2 = 4'd2;
    #1;
    checks++;
    if ({bus.ready1, bus.value1, bus.ready2, bus.value2} !==
        {1'b1, 32'hABCD, 1'b1, 32'h77}) begin
      errors++;
      $display("FAIL dual_cdb got=%b/%h/%b/%h want=1/abcd/1/77",
        bus.ready1, bus.value1, bus.ready2, bus.value2);
    end
    idle();
  endtask

  task automatic test_mispredict;
    bit found;
    bit seen;
    do_reset();
    drive_issue(2'd2, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    drive_issue(2'd0, 5'd7, 1'b0, 1'b1, 32'h99);
    tick();
    idle();
    bus.rs_cdb_valid = 1'b1;
    bus.rs_cdb_entry = 4'd0;
    bus.rs_cdb_value = 32'h1;
    bus.rs_cdb_addr  = 32'h100;
    tick();
    idle();
    found = 0;
    seen = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.commit_reg_id != 5'd0) seen = 1;
      if (bus.rob_clear_up) found = 1;
    end
    checks++;
    if (!found || bus.jump_pc !== 32'h100) begin
      errors++;
      $display("FAIL flush_pulse got=%b/%h want=1/00000100",
        found, bus.jump_pc);
    end
    drive_issue(2'd0, 5'd9, 1'b0, 1'b1, 32'h42);
    tick();
    idle();
    checks++;
    if ({bus.rob_clear_up, bus.rob_full} !== 2'b00 ||
        bus.issue_rob_entry !== 4'd0 ||
        bus.rob_head !== 4'd0) begin
      errors++;
      $display("FAIL flush_after got=%b%b/%0d/%0d want=00/0/0",
        bus.rob_clear_up, bus.rob_full,
        bus.issue_rob_entry, bus.rob_head);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.commit_reg_id != 5'd0) seen = 1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_young got=commit want=none");
    end
  endtask

  task automatic test_store_halt;
    bit found;
    do_reset();
    drive_issue(2'd1, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    drive_issue(2'd3, 5'd0, 1'b0, 1'b1, 32'h0);
    tick();
    idle();
    bus.lsb_cdb_valid = 1'b1;
    bus.lsb_cdb_entry = 4'd0;
    tick();
    idle();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.commit_store) found = 1;
    end
    checks++;
    if (!found || bus.commit_reg_id !== 5'd0) begin
      errors++;
      $display("FAIL store_pulse got=%b/%0d want=1/0",
        found, bus.commit_reg_id);
    end
    tick();
    checks++;
    if (bus.commit_store !== 1'b0 || bus.halt_out !== 1'b1) begin
      errors++;
      $display("FAIL halt_set got=%b/%b want=0/1",
        bus.commit_store, bus.halt_out);
    end
    drive_issue(2'd0, 5'd4, 1'b0, 1'b1, 32'h44);
    tick();
    idle();
    found = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.commit_reg_id != 5'd0) found = 1;
    end
    checks++;
    if (found || bus.issue_rob_entry !== 4'd2 ||
        bus.halt_out !== 1'b1) begin
      errors++;
      $display("FAIL halt_block got=%b/%0d/%b want=0/2/1",
        found, bus.issue_rob_entry, bus.halt_out);
    end
  endtask

  task automatic test_rdy_hold;
    bit found;
    bit early;
    exp_t e;
    do_reset();
    drive_issue(2'd0, 5'd3, 1'b0, 1'b1, 32'h3333);
    tick();
    idle();
    rdy_in = 1'b0;
    sb.push_back('{5'd3, 32'h3333, 4'd0});
    early = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.commit_reg_id != 5'd0) early = 1;
    end
    checks++;
    if (early || bus.rob_head !== 4'd0) begin
      errors++;
      $display("FAIL rdy_hold got=%b/%0d want=0/0",
        early, bus.rob_head);
    end
    rdy_in = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.commit_reg_id != 5'd0) found = 1;
    end
    checks++;
    if (!found || sb.size() == 0) begin
      errors++;
      $display("FAIL rdy_commit got=found%0d want=found1", found);
    end else begin
      e = sb.pop_front();
      if ({bus.commit_reg_id, bus.commit_reg_data,
           bus.commit_rob_entry} !== {e.rd, e.data, e.entry}) begin
        errors++;
        $display("FAIL rdy_commit got=%0d/%h/%0d want=%0d/%h/%0d",
          bus.commit_reg_id, bus.commit_reg_data,
          bus.commit_rob_entry, e.rd, e.data, e.entry);
      end
    end
    tick();
    checks++;
    if (bus.commit_reg_id !== 5'd0 || bus.rob_head !== 4'd1) begin
      errors++;
      $display("FAIL rdy_single got=id%0d head%0d want=id0 head1",
        bus.commit_reg_id, bus.rob_head);
    end
  endtask

  initial begin
    idle();
    @(negedge clk_in);
    test_reset();
    test_reg_commit();
    test_full_wrap();
    test_query_bypass();
    test_mispredict();
    test_store_halt();
    test_rdy_hold();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rob_buffer.md
Name: rob_buffer

Overview:
- Reorder buffer for the out-of-order core; sits directly downstream of issue and upstream of the register status file.
- Allocates one entry per issued instruction and captures results from the two CDBs.
- Answers same-cycle operand queries from the register file and commits in program order.
- Drives the register-file commit port and the LSB store-release port; flushes the whole machine on a branch mispredict.

Parameters:
- ROB_BIT, 4, log2 of entry count (16 entries); matches the shared `ROB_BIT constant.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global enable; all state holds when low
- issue_valid  in  1  allocate entry at tail this cycle
- issue_type  in  2  0=REG, 1=STORE, 2=BRANCH, 3=HALT
- issue_rd  in  5  destination register (REG only; 0 = no write)
- issue_pc  in  32  instruction PC
- issue_pred_taken  in  1  predictor decision (BRANCH)
- issue_ready  in  1  result already known at issue (LUI/AUIPC/JAL)
- issue_value  in  32  result when issue_ready
- rob_full  out  ROB-full flag
- issue_rob_entry  out  ROB_BIT  current tail index; tag for the issuing instruction
- rs_cdb_valid, rs_cdb_entry, rs_cdb_value  in  1/ROB_BIT/32  ALU broadcast; for BRANCH, value[0] = actual taken
- rs_cdb_addr  in  32  correct redirect PC for BRANCH
- lsb_cdb_valid, lsb_cdb_entry, lsb_cdb_value  in  1/ROB_BIT/32  load result, or store-address-ready
- get_rob_entry1 / get_rob_entry2  in  ROB_BIT  operand query tags
- ready1 / ready2  out  1  queried entry has a result (combinational, includes same-cycle CDB)
- value1 / value2  out  32  queried result (CDB value wins if matching this cycle)
- commit_reg_id  out  5  register written at commit; 0 = none
- commit_reg_data  out  32  committed value
- commit_rob_entry  out  ROB_BIT  entry index committed
- commit_store  out  1  one-cycle pulse releasing the head store in the LSB
- rob_head  out  ROB_BIT  head index
- rob_clear_up  out  1  one-cycle flush pulse
- jump_pc  out  32  redirect PC, valid with rob_clear_up
- halt_out  out  1  sticky; set when a HALT entry commits

Behaviour:
- Storage:
  - Circular array: busy, ready, type, rd, value, pc, pred, addr per entry.
  - head, tail, count registers; count is ROB_BIT+1 bits.
  - rob_full = (count == 2^ROB_BIT).
- Reset (rst_in==0 at posedge):
  - head, tail, count cleared; all busy cleared.
  - All registered outputs 0; halt_out=0.
- rdy_in low: no state or output change.
- Issue:
  - When issue_valid && !rob_full && !rob_clear_up, write entry at tail with busy=1 and ready=issue_ready; tail wraps modulo 2^ROB_BIT.
  - issue_valid while full is ignored; the decoder must hold.
- Writeback:
  - Each CDB with valid sets ready=1 and value for its entry.
  - rs CDB also stores addr.
  - Both CDBs in one cycle on different entries are both applied.
  - Writes to non-busy entries are dropped.
- Commit:
  - At most one per cycle, when head is busy && ready.
  - Registered outputs update on that edge; otherwise commit_reg_id=0 and commit_store=0 on the next edge.
  - REG: commit_reg_id=rd, commit_reg_data=value, commit_rob_entry=head.
  - STORE: commit_store=1 for one cycle.
  - HALT: halt_out=1; no further commits or issues are accepted.
  - BRANCH with value[0]==pred: plain retire.
  - BRANCH with value[0]!=pred: rob_clear_up=1 and jump_pc=addr on the same edge.
- Flush:
  - In the cycle rob_clear_up is high, issue and CDB writes are ignored.
  - At the next enabled edge, head=tail=count=0, all busy=0, rob_clear_up returns to 0.
- Simultaneous issue and commit: count unchanged.
  - Issue into a full ROB is still refused even if a commit happens that cycle; full uses the pre-edge count.
- Query:
  - Combinational.
  - ready = entry.ready || (matching CDB valid this cycle).
  - Querying a non-busy entry returns ready=1 with a stale value; the register file only queries dirty regs.

Decomposition:
- Shared package/include: `ROB_BIT, type encodings (ROB_REG/STORE/BRANCH/HALT), width constants.
- One natural sub-module, rob_query_port: combinational tag → ready/value lookup with CDB bypass, instantiated twice.

Test Plan:
- Reset: drive rst_in=0 for 2 cycles → count=0, rob_full=0, commit_reg_id=0, rob_clear_up=0, halt_out=0.
- Issue REG rd=5 with issue_ready=0 at entry 0; rs CDB entry 0, value 0x1234 → next edge commit_reg_id=5, data=0x1234, entry=0.
- Issue 16 entries → rob_full=1; a 17th issue_valid is ignored and tail stays 0; commit one → full drops and the next issue lands at entry 0 (wrap).
- Query bypass: get_rob_entry1=3 while rs_cdb_valid with entry 3, value 0xABCD in the same cycle → ready1=1, value1=0xABCD.
- BRANCH pred=0, CDB value=1, addr=0x100 at head → rob_clear_up=1, jump_pc=0x100 for exactly one cycle; then count=0, and the younger REG entry never commits.
- rdy_in=0 while head is ready → no commit until rdy_in returns, then exactly one commit pulse.
